qpll_bringup_sequencer: RTL and testbench
=========================================

// Module: qpll_bringup_sequencer
// PURPOSE
//   Parametrised power-up/reset/lock sequencer for NUM_QPLL GTXE2_COMMON QPLLs.
//   Drives QPLLPD/QPLLRESET per quad and debounces QPLLLOCK.
//   Retries on lock timeout and recovers on lock loss.
//   Sits between the PHY top-level enable and the transceiver common blocks;
//   done_o gates channel-level (GTXE2_CHANNEL) reset release.
// PARAMETERS
//   NUM_QPLL             1      number of QPLLs sequenced together (>=1)
//   PWRUP_WAIT_CYCLES    1000   cycles after QPLLPD release before reset sequencing
//   RESET_CYCLES         16     QPLLRESET pulse width, cycles (>=1)
//   LOCK_TIMEOUT_CYCLES  65536  max cycles in WAIT_LOCK per attempt
//   LOCK_DEBOUNCE_CYCLES 8      consecutive synced-high lock cycles to accept lock (>=1)
//   MAX_RETRIES          3      extra reset attempts after first timeout (0..15)
// PORTS
//   clk                 in   1         free-running system/DRP clock
//   rst                 in   1         synchronous, active-high reset
//   enable_i            in   1         level; 1 = bring up QPLLs, 0 = power down
//   qpll_lock_i         in   NUM_QPLL  QPLLLOCK, asynchronous to clk
//   qpll_refclklost_i   in   NUM_QPLL  QPLLREFCLKLOST, asynchronous to clk
//   qpll_pd_o           out  NUM_QPLL  to QPLLPD
//   qpll_reset_o        out  NUM_QPLL  to QPLLRESET
//   done_o              out  1         all QPLLs locked and debounced
//   fail_o              out  1         sticky: retries exhausted
//   fail_mask_o         out  NUM_QPLL  QPLLs not locked at final timeout
//   lost_lock_o         out  1         1-cycle pulse on lock loss while LOCKED
//   retry_cnt_o         out  4         timeouts in current bring-up attempt
// BEHAVIOUR
//   - rst: state IDLE.
//     pd/reset outputs all-ones; done/fail/lost 0; fail_mask 0; retry_cnt 0.
//   - rst mid-operation aborts immediately; no state is preserved.
//   - Async inputs pass 2-flop synchronisers (2-cycle latency).
//     Lock logic sees only synced values.
//   - A per-QPLL debounce counter saturates at LOCK_DEBOUNCE_CYCLES.
//     It clears on any cycle where lock=0 or refclklost=1.
//     ok[i] = counter saturated.
//   - FSM states IDLE, PWRUP, RESET, WAIT_LOCK, LOCKED, FAIL.
//     - IDLE: pd=1, reset=1. enable_i=1 -> PWRUP.
//     - PWRUP: pd=0, reset=1 for exactly PWRUP_WAIT_CYCLES cycles -> RESET.
//     - RESET: reset=1 for exactly RESET_CYCLES cycles -> WAIT_LOCK.
//       Debounce counters and timeout counter cleared.
//     - WAIT_LOCK: reset=0. When all ok[i]=1 -> LOCKED; done_o=1 from the next cycle.
//       On timer reaching LOCK_TIMEOUT_CYCLES:
//       - retry_cnt<MAX_RETRIES: retry_cnt+1 -> RESET.
//       - otherwise: -> FAIL; fail_mask_o = ~ok captured that cycle.
//       - If all-ok and timeout occur in the same cycle, lock wins.
//     - LOCKED: done_o=1. Any synced lock=0 or refclklost=1:
//       done_o=0, lost_lock_o pulse, retry_cnt=0 -> RESET (same cycle as pulse).
//     - FAIL: fail_o=1, pd=0, reset=1. Exits only via enable_i=0.
//   - enable_i=0 in any state -> IDLE next cycle.
//     pd/reset all-ones, done/fail/mask/retry cleared, no lost_lock pulse.
//   - All outputs registered. Counters are sized by $clog2 of their parameter.
//     They saturate and never wrap.
// TESTING
//   (params: NUM_QPLL=2, PWRUP=10, RESET=4, TIMEOUT=50, DEBOUNCE=3, RETRIES=2)
//   1. enable_i=1 at cycle 0; both locks high from cycle 20 ->
//      pd_o=00 from cycle 1, reset_o=00 from cycle 15, done_o=1 at cycle 26.
//   2. lock[1] held 0 -> reset_o re-pulses at 50-cycle intervals, retry_cnt 1 then 2;
//      third timeout -> fail_o=1, fail_mask_o=2'b10, reset_o=11, done_o=0.
//   3. lock[0] high 2 cycles, low 1, then high 2 (debounce 3) -> done_o stays 0;
//      then high 3 cycles -> done_o=1.
//   4. In LOCKED, lock[0] low 1 cycle ->
//      lost_lock_o 1-cycle pulse, done_o=0, reset_o=11 for 4 cycles, retry_cnt=0.
//   5. enable_i=0 mid-WAIT_LOCK -> next cycle pd_o=11, reset_o=11, retry_cnt=0;
//      re-enable -> full PWRUP of 10 cycles repeats.
//   6. rst pulse while LOCKED and while FAIL -> next edge all outputs at reset values.

Source files
------------

// File: rtl/qpll_bringup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : qpll_bringup_sequencer
// Description : Power-up / reset / lock sequencer for a group of GTXE2_COMMON
//               QPLLs. Drives QPLLPD and QPLLRESET, synchronises and debounces
//               QPLLLOCK, retries on lock timeout and recovers on lock loss.
//               done_o gates release of the channel-level resets.
// Revision    : 1.0 - initial release
// ============================================================================
module qpll_bringup_sequencer #(
    parameter int NUM_QPLL             = 1,
    parameter int PWRUP_WAIT_CYCLES    = 1000,
    parameter int RESET_CYCLES         = 16,
    parameter int LOCK_TIMEOUT_CYCLES  = 65536,
    parameter int LOCK_DEBOUNCE_CYCLES = 8,
    parameter int MAX_RETRIES          = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic [NUM_QPLL-1:0] qpll_lock_i,
    input  logic [NUM_QPLL-1:0] qpll_refclklost_i,
    output logic [NUM_QPLL-1:0] qpll_pd_o,
    output logic [NUM_QPLL-1:0] qpll_reset_o,
    output logic                done_o,
    output logic                fail_o,
    output logic [NUM_QPLL-1:0] fail_mask_o,
    output logic                lost_lock_o,
    output logic [3:0]          retry_cnt_o
);

    // ------------------------------------------------------------------------
    // Derived constants. Zero-length phases are treated as one cycle so every
    // counter has at least one bit and a well-defined terminal value.
    // ------------------------------------------------------------------------
    localparam int PW_EFF = (PWRUP_WAIT_CYCLES    < 1) ? 1 : PWRUP_WAIT_CYCLES;
    localparam int RS_EFF = (RESET_CYCLES         < 1) ? 1 : RESET_CYCLES;
    localparam int TO_EFF = (LOCK_TIMEOUT_CYCLES  < 1) ? 1 : LOCK_TIMEOUT_CYCLES;
    localparam int DB_EFF = (LOCK_DEBOUNCE_CYCLES < 1) ? 1 : LOCK_DEBOUNCE_CYCLES;

    localparam int PW_W = (PW_EFF > 1) ? $clog2(PW_EFF) : 1;
    localparam int RS_W = (RS_EFF > 1) ? $clog2(RS_EFF) : 1;
    localparam int TO_W = (TO_EFF > 1) ? $clog2(TO_EFF) : 1;
    localparam int DB_W = $clog2(DB_EFF + 1);

    localparam logic [PW_W-1:0] PW_LAST   = PW_W'(PW_EFF - 1);
    localparam logic [RS_W-1:0] RS_LAST   = RS_W'(RS_EFF - 1);
    localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TO_EFF - 1);
    localparam logic [DB_W-1:0] DB_SAT    = DB_W'(DB_EFF);
    localparam logic [3:0]      RETRY_MAX = 4'(MAX_RETRIES);

    // State encoding
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PWRUP     = 3'd1;
    localparam logic [2:0] S_RESET     = 3'd2;
    localparam logic [2:0] S_WAIT_LOCK = 3'd3;
    localparam logic [2:0] S_LOCKED    = 3'd4;
    localparam logic [2:0] S_FAIL      = 3'd5;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    logic [2:0]          state_q, state_d;

    logic [NUM_QPLL-1:0] lock_meta_q, lock_sync_q;
    logic [NUM_QPLL-1:0] rcl_meta_q,  rcl_sync_q;

    logic [PW_W-1:0]     pw_cnt_q, pw_cnt_d;
    logic [RS_W-1:0]     rs_cnt_q, rs_cnt_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;

    logic [NUM_QPLL-1:0] w_ok;
    logic                w_all_ok;
    logic                w_pw_done;
    logic                w_rs_done;
    logic                w_to_done;
    logic                w_timeout_evt;
    logic                w_lost_evt;

    logic [NUM_QPLL-1:0] pd_q, pd_d;
    logic [NUM_QPLL-1:0] reset_q, reset_d;
    logic                done_q, done_d;
    logic                fail_q, fail_d;
    logic [NUM_QPLL-1:0] mask_q, mask_d;
    logic                lost_q, lost_d;
    logic [3:0]          retry_q, retry_d;

    // ------------------------------------------------------------------------
    // Two-flop synchronisers for the asynchronous QPLL status inputs
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_meta_q <= '0;
            lock_sync_q <= '0;
            rcl_meta_q  <= '0;
            rcl_sync_q  <= '0;
        end else begin
            lock_meta_q <= qpll_lock_i;
            lock_sync_q <= lock_meta_q;
            rcl_meta_q  <= qpll_refclklost_i;
            rcl_sync_q  <= rcl_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Per-QPLL lock debounce: count consecutive good synced cycles, saturate
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_QPLL; gi++) begin : g_debounce
            logic [DB_W-1:0] db_cnt_q, db_cnt_d;

            // Next debounce count: cleared by RESET or any bad sample
            always_comb begin
                db_cnt_d = db_cnt_q;
                if ((state_q == S_RESET) || !lock_sync_q[gi] || rcl_sync_q[gi]) begin
                    db_cnt_d = '0;
                end else if (db_cnt_q != DB_SAT) begin
                    db_cnt_d = db_cnt_q + 1'b1;
                end
            end

            // Debounce counter register
            always_ff @(posedge clk) begin
                if (rst) begin
                    db_cnt_q <= '0;
                end else begin
                    db_cnt_q <= db_cnt_d;
                end
            end

            assign w_ok[gi] = (db_cnt_q == DB_SAT);
        end
    endgenerate

    assign w_all_ok  = &w_ok;
    assign w_pw_done = (pw_cnt_q == PW_LAST);
    assign w_rs_done = (rs_cnt_q == RS_LAST);
    assign w_to_done = (to_cnt_q == TO_LAST);

    // Lock wins over a coincident timeout
    assign w_timeout_evt = (state_q == S_WAIT_LOCK) && w_to_done && !w_all_ok;
    assign w_lost_evt    = (state_q == S_LOCKED) && (!(&lock_sync_q) || (|rcl_sync_q));

    // ------------------------------------------------------------------------
    // Phase timers: count only while resident in their state, stop at the
    // terminal value, and read zero on every fresh entry
    // ------------------------------------------------------------------------
    always_comb begin
        pw_cnt_d = '0;
        rs_cnt_d = '0;
        to_cnt_d = '0;
        if (state_q == S_PWRUP) begin
            pw_cnt_d = w_pw_done ? pw_cnt_q : pw_cnt_q + 1'b1;
        end
        if (state_q == S_RESET) begin
            rs_cnt_d = w_rs_done ? rs_cnt_q : rs_cnt_q + 1'b1;
        end
        if (state_q == S_WAIT_LOCK) begin
            to_cnt_d = w_to_done ? to_cnt_q : to_cnt_q + 1'b1;
        end
    end

    // Phase timer registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pw_cnt_q <= '0;
            rs_cnt_q <= '0;
            to_cnt_q <= '0;
        end else begin
            pw_cnt_q <= pw_cnt_d;
            rs_cnt_q <= rs_cnt_d;
            to_cnt_q <= to_cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; dropping enable_i overrides everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (enable_i)  state_d = S_PWRUP;
            S_PWRUP:     if (w_pw_done) state_d = S_RESET;
            S_RESET:     if (w_rs_done) state_d = S_WAIT_LOCK;
            S_WAIT_LOCK: begin
                if (w_all_ok) begin
                    state_d = S_LOCKED;
                end else if (w_to_done) begin
                    state_d = (retry_q < RETRY_MAX) ? S_RESET : S_FAIL;
                end
            end
            S_LOCKED:    if (w_lost_evt) state_d = S_RESET;
            S_FAIL:      state_d = S_FAIL;
            default:     state_d = S_IDLE;
        endcase
        if (!enable_i) begin
            state_d = S_IDLE;
        end
    end

    // FSM output logic: values for the output registers, decoded from the
    // state being entered so that outputs change together with the state
    always_comb begin
        pd_d    = (state_d == S_IDLE) ? '1 : '0;
        reset_d = ((state_d == S_WAIT_LOCK) || (state_d == S_LOCKED)) ? '0 : '1;
        done_d  = (state_d == S_LOCKED);
        fail_d  = (state_d == S_FAIL);
        lost_d  = enable_i && w_lost_evt;
        retry_d = retry_q;
        mask_d  = mask_q;
        if (!enable_i) begin
            retry_d = '0;
            mask_d  = '0;
        end else if (w_lost_evt) begin
            retry_d = '0;
        end else if (w_timeout_evt) begin
            if (retry_q < RETRY_MAX) begin
                retry_d = retry_q + 4'd1;
            end else begin
                mask_d  = ~w_ok;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pd_q    <= '1;
            reset_q <= '1;
            done_q  <= 1'b0;
            fail_q  <= 1'b0;
            mask_q  <= '0;
            lost_q  <= 1'b0;
            retry_q <= '0;
        end else begin
            pd_q    <= pd_d;
            reset_q <= reset_d;
            done_q  <= done_d;
            fail_q  <= fail_d;
            mask_q  <= mask_d;
            lost_q  <= lost_d;
            retry_q <= retry_d;
        end
    end

    assign qpll_pd_o    = pd_q;
    assign qpll_reset_o = reset_q;
    assign done_o       = done_q;
    assign fail_o       = fail_q;
    assign fail_mask_o  = mask_q;
    assign lost_lock_o  = lost_q;
    assign retry_cnt_o  = retry_q;

endmodule
`default_nettype wire

// File: tb/tb_qpll_bringup_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_qpll_bringup_sequencer
// Description : Scoreboard bench for qpll_bringup_sequencer. A phase/countdown
//               reference model predicts the registered outputs for each
//               clock edge; a monitor pops and compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_qpll_bringup_sequencer;

    localparam int N  = 2;
    localparam int PW = 10;
    localparam int RS = 4;
    localparam int TO = 50;
    localparam int DB = 3;
    localparam int MR = 2;

    // Reference-model phases
    localparam int PH_IDLE   = 0;
    localparam int PH_PWRUP  = 1;
    localparam int PH_RESET  = 2;
    localparam int PH_WAIT   = 3;
    localparam int PH_LOCKED = 4;
    localparam int PH_FAIL   = 5;

    logic         clk    = 1'b0;
    logic         rst    = 1'b1;
    logic         enable = 1'b0;
    logic [N-1:0] lock   = '0;
    logic [N-1:0] rcl    = '0;

    logic [N-1:0] pd_o, reset_o, mask_o;
    logic         done_o, fail_o, lost_o;
    logic [3:0]   retry_o;

    qpll_bringup_sequencer #(
        .NUM_QPLL            (N),
        .PWRUP_WAIT_CYCLES   (PW),
        .RESET_CYCLES        (RS),
        .LOCK_TIMEOUT_CYCLES (TO),
        .LOCK_DEBOUNCE_CYCLES(DB),
        .MAX_RETRIES         (MR)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .enable_i         (enable),
        .qpll_lock_i      (lock),
        .qpll_refclklost_i(rcl),
        .qpll_pd_o        (pd_o),
        .qpll_reset_o     (reset_o),
        .done_o           (done_o),
        .fail_o           (fail_o),
        .fail_mask_o      (mask_o),
        .lost_lock_o      (lost_o),
        .retry_cnt_o      (retry_o)
    );

    always #5 clk = ~clk;

    // {pd[1:0], reset[1:0], done, fail, mask[1:0], lost, retry[3:0]}
    typedef logic [12:0] exp_t;
    exp_t exp_q[$];

    int checks   = 0;
    int errors   = 0;
    int edge_cnt = 0;
    int last_cyc = 0;

    bit track_en   = 1'b0;
    int first_pd   = -1;
    int first_rst  = -1;
    int first_done = -1;

    // ---------------- reference model state ----------------
    int       m_phase   = PH_IDLE;
    int       m_left    = 0;
    int       m_good[N];
    int       m_retries = 0;
    bit [1:0] m_mask    = '0;
    bit       m_lost    = 1'b0;
    bit [1:0] m_s1l = '0, m_s2l = '0, m_s1r = '0, m_s2r = '0;

    // Advance the model across one clock edge given the inputs of that cycle
    task automatic model_edge(input bit r, input bit en, input bit [1:0] lk, input bit [1:0] rc);
        int       old_phase;
        bit [1:0] okv;
        if (r) begin
            m_phase = PH_IDLE; m_left = 0; m_retries = 0; m_mask = '0; m_lost = 1'b0;
            m_s1l = '0; m_s2l = '0; m_s1r = '0; m_s2r = '0;
            for (int i = 0; i < N; i++) m_good[i] = 0;
            return;
        end
        old_phase = m_phase;
        for (int i = 0; i < N; i++) okv[i] = (m_good[i] >= DB);
        m_lost = 1'b0;
        if (!en) begin
            m_phase = PH_IDLE; m_retries = 0; m_mask = '0;
        end else begin
            case (old_phase)
                PH_IDLE: begin m_phase = PH_PWRUP; m_left = PW; end
                PH_PWRUP: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_RESET; m_left = RS; end
                end
                PH_RESET: begin
                    m_left--;
                    if (m_left == 0) begin m_phase = PH_WAIT; m_left = TO; end
                end
                PH_WAIT: begin
                    if (&okv) begin
                        m_phase = PH_LOCKED;
                    end else begin
                        m_left--;
                        if (m_left == 0) begin
                            if (m_retries < MR) begin
                                m_retries++; m_phase = PH_RESET; m_left = RS;
                            end else begin
                                m_phase = PH_FAIL; m_mask = ~okv;
                            end
                        end
                    end
                end
                PH_LOCKED: begin
                    if (m_s2l != 2'b11 || m_s2r != 2'b00) begin
                        m_phase = PH_RESET; m_left = RS; m_lost = 1'b1; m_retries = 0;
                    end
                end
                default: ;
            endcase
        end
        for (int i = 0; i < N; i++) begin
            if (old_phase == PH_RESET)            m_good[i] = 0;
            else if (m_s2l[i] && !m_s2r[i])       m_good[i] = (m_good[i] < DB) ? m_good[i] + 1 : DB;
            else                                  m_good[i] = 0;
        end
        m_s2l = m_s1l; m_s1l = lk;
        m_s2r = m_s1r; m_s1r = rc;
    endtask

    function automatic exp_t model_out();
        logic [1:0] pdv, rsv;
        logic [3:0] rt;
        pdv = (m_phase == PH_IDLE) ? 2'b11 : 2'b00;
        rsv = (m_phase == PH_WAIT || m_phase == PH_LOCKED) ? 2'b00 : 2'b11;
        rt  = 4'(m_retries);
        return {pdv, rsv, (m_phase == PH_LOCKED), (m_phase == PH_FAIL), m_mask, m_lost, rt};
    endfunction

    // Apply one cycle of stimulus and queue the predicted post-edge outputs
    task automatic drive(input bit r, input bit en, input bit [1:0] lk, input bit [1:0] rc);
        @(negedge clk);
        rst = r; enable = en; lock = lk; rcl = rc;
        last_cyc = edge_cnt;
        model_edge(r, en, lk, rc);
        exp_q.push_back(model_out());
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Monitor: compare DUT outputs with the scoreboard after every edge
    initial begin
        forever begin
            exp_t e;
            exp_t a;
            @(posedge clk);
            edge_cnt++;
            #1;
            if (track_en) begin
                if (first_pd   < 0 && pd_o    == 2'b00) first_pd   = edge_cnt;
                if (first_rst  < 0 && reset_o == 2'b00) first_rst  = edge_cnt;
                if (first_done < 0 && done_o)           first_done = edge_cnt;
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = {pd_o, reset_o, done_o, fail_o, mask_o, lost_o, retry_o};
                checks++;
                if (a !== e) begin
                    errors++;
                    $display("FAIL outputs cycle %0d: got %b, expected %b (pd,reset,done,fail,mask,lost,retry)",
                             edge_cnt, a, e);
                end
            end
        end
    end

    // Stimulus
    initial begin
        int c0;
        bit p [9];
        bit en_r;
        bit [1:0] lk_r;
        for (int i = 0; i < N; i++) m_good[i] = 0;

        repeat (3) drive(1'b1, 1'b0, 2'b00, 2'b00);

        // Straight bring-up with absolute timing landmarks
        first_pd = -1; first_rst = -1; first_done = -1; track_en = 1'b1;
        drive(1'b0, 1'b1, 2'b00, 2'b00);
        c0 = last_cyc;
        for (int k = 1; k < 40; k++) drive(1'b0, 1'b1, (k >= 20) ? 2'b11 : 2'b00, 2'b00);
        track_en = 1'b0;
        check_int("pd_release_cycle",   first_pd   - c0, 1);
        check_int("reset_release_cycle", first_rst - c0, 15);
        check_int("done_rise_cycle",    first_done - c0, 26);

        // Single-cycle lock drop while locked, then relock
        drive(1'b0, 1'b1, 2'b10, 2'b00);
        repeat (40) drive(1'b0, 1'b1, 2'b11, 2'b00);

        // Debounce: glitchy lock[0] during WAIT_LOCK
        repeat (9) drive(1'b0, 1'b1, 2'b10, 2'b00);
        p = '{1, 1, 0, 1, 1, 0, 1, 1, 1};
        for (int i = 0; i < 9; i++) drive(1'b0, 1'b1, {1'b1, p[i]}, 2'b00);
        repeat (12) drive(1'b0, 1'b1, 2'b11, 2'b00);

        // lock[1] stuck low: retries then FAIL
        repeat (200) drive(1'b0, 1'b1, 2'b01, 2'b00);

        // rst while FAIL, bring up again, rst while LOCKED
        drive(1'b1, 1'b1, 2'b01, 2'b00);
        repeat (40) drive(1'b0, 1'b1, 2'b11, 2'b00);
        drive(1'b1, 1'b1, 2'b11, 2'b00);

        // Disable mid-WAIT_LOCK, then re-enable and lock
        repeat (25) drive(1'b0, 1'b1, 2'b00, 2'b00);
        repeat (2)  drive(1'b0, 1'b0, 2'b00, 2'b00);
        repeat (40) drive(1'b0, 1'b1, 2'b11, 2'b00);

        // Randomised traffic
        en_r = 1'b1;
        lk_r = 2'b11;
        for (int c = 0; c < 3000; c++) begin
            bit       r_r;
            bit [1:0] rc_r;
            r_r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 149) == 0) en_r = ~en_r;
            rc_r = 2'b00;
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 39) == 0)  lk_r[i] = ~lk_r[i];
                if ($urandom_range(0, 299) == 0) rc_r[i] = 1'b1;
            end
            drive(r_r, en_r, lk_r, rc_r);
        end

        @(posedge clk);
        #2;
        check_int("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
